// File: rtl/div_measure_pkg.sv
// rtl/div_measure_pkg.sv - shared defines, state encodings and types for div_measure.
// Optional duty-cycle checking is built only when DIV_MEASURE_DUTY_CHECK_EN is defined.
`ifndef DIV_MEASURE_DEFINES
`define DIV_MEASURE_DEFINES
`define SIZE 4
`define DM_IDLE      2'd0
`define DM_WAIT_RISE 2'd1
`define DM_MEAS_HIGH 2'd2
`define DM_MEAS_LOW  2'd3
`endif

package div_measure_pkg;
  localparam int SIZE_W = `SIZE;

  typedef enum logic [1:0] {
    S_IDLE      = `DM_IDLE,
    S_WAIT_RISE = `DM_WAIT_RISE,
    S_MEAS_HIGH = `DM_MEAS_HIGH,
    S_MEAS_LOW  = `DM_MEAS_LOW
  } dm_state_t;
endpackage

// File: rtl/div_measure_edge_sync.sv
// rtl/div_measure_edge_sync.sv - two-flop synchronizer plus delay flop producing rise/fall pulses.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/div_measure.sv
// rtl/div_measure.sv - measures period, high and low time of a divided clock; detects lock and overflow.
// Define DIV_MEASURE_DUTY_CHECK_EN to build the duty-cycle comparator behind duty_err.
module div_measure
  import div_measure_pkg::*;
#(
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_in,
  output logic [`SIZE-1:0] n_meas,
  output logic [`SIZE-1:0] high_cnt,
  output logic [`SIZE-1:0] low_cnt,
  output logic             meas_valid,
  output logic             odd,
  output logic             locked,
  output logic             ovf,
  output logic             duty_err
);
  localparam logic [`SIZE-1:0] CNT_MAX = '1;
  localparam int MW = $clog2(LOCK_CNT + 1);

  dm_state_t        state_q, state_d;
  logic [`SIZE-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [`SIZE:0]   sum;
  logic [MW-1:0]    match_q, match_d;
  logic             rise, fall, publish, overflow;

  edge_sync u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .din   (div_in),
    .rise  (rise),
    .fall  (fall)
  );

  assign sum = {1'b0, hi_q} + {1'b0, lo_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    publish  = 1'b0;
    overflow = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT_RISE;
        S_WAIT_RISE: begin
          if (rise) begin
            state_d = S_MEAS_HIGH;
            hi_d    = `SIZE'(1);
            lo_d    = '0;
          end
        end
        S_MEAS_HIGH: begin
          if (hi_q == CNT_MAX) overflow = 1'b1;
          else if (fall) begin
            state_d = S_MEAS_LOW;
            lo_d    = `SIZE'(1);
          end else hi_d = hi_q + `SIZE'(1);
        end
        S_MEAS_LOW: begin
          if (lo_q == CNT_MAX) overflow = 1'b1;
          else if (rise) begin
            // Next period starts on the same rise edge, so no edge is lost.
            if (sum[`SIZE]) overflow = 1'b1;
            else publish = 1'b1;
            state_d = S_MEAS_HIGH;
            hi_d    = `SIZE'(1);
            lo_d    = '0;
          end else lo_d = lo_q + `SIZE'(1);
        end
        default: state_d = S_IDLE;
      endcase
      if (overflow) state_d = S_WAIT_RISE;
    end
  end

  always_comb begin
    match_d = MW'(1);
    if (match_q != '0 && sum[`SIZE-1:0] == n_meas)
      match_d = (match_q == MW'(LOCK_CNT)) ? match_q : match_q + MW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_meas     <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      meas_valid <= 1'b0;
      odd        <= 1'b0;
      locked     <= 1'b0;
      ovf        <= 1'b0;
      match_q    <= '0;
    end else begin
      meas_valid <= publish;
      if (!enable) begin
        locked  <= 1'b0;
        ovf     <= 1'b0;
        match_q <= '0;
      end else if (overflow) begin
        ovf     <= 1'b1;
        locked  <= 1'b0;
        match_q <= '0;
      end else if (publish) begin
        n_meas   <= sum[`SIZE-1:0];
        high_cnt <= hi_q;
        low_cnt  <= lo_q;
        odd      <= sum[0];
        match_q  <= match_d;
        locked   <= (match_d == MW'(LOCK_CNT));
      end
    end
  end

`ifdef DIV_MEASURE_DUTY_CHECK_EN
  logic [`SIZE-1:0] diff;
  assign diff = (hi_q > lo_q) ? hi_q - lo_q : lo_q - hi_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) duty_err <= 1'b0;
    else if (publish && enable) duty_err <= (diff > `SIZE'(1));
  end
`else
  assign duty_err = 1'b0;
`endif
endmodule

// File: tb/tb_div_measure.sv
// tb/tb_div_measure.sv - randomized bench for div_measure with a timestamp-based reference model.
module tb_div_measure;
  import div_measure_pkg::*;

  localparam int LOCK = 4;
  localparam int MAXC = (1 << SIZE_W) - 1;
`ifdef DIV_MEASURE_DUTY_CHECK_EN
  localparam bit DUTY_ON = 1'b1;
`else
  localparam bit DUTY_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic div_in = 1'b0;
  logic [SIZE_W-1:0] n_meas, high_cnt, low_cnt;
  logic meas_valid, odd, locked, ovf, duty_err;

  int n_tests = 0;
  int n_fail = 0;

  div_measure #(.LOCK_CNT(LOCK)) dut (
    .clk(clk), .reset(reset), .enable(enable), .div_in(div_in),
    .n_meas(n_meas), .high_cnt(high_cnt), .low_cnt(low_cnt),
    .meas_valid(meas_valid), .odd(odd), .locked(locked), .ovf(ovf), .duty_err(duty_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Divided-clock generator; new settings take effect at a period boundary unless immediate.
  int  g_n = 4, g_h = 2, g_cnt = 0;
  bit  g_static = 1'b1, g_level = 1'b0;
  int  p_n, p_h;
  bit  p_static, p_level, p_imm, pend = 1'b0;

  always @(negedge clk) begin
    if (pend && (p_imm || g_cnt == 0)) begin
      g_n = p_n; g_h = p_h; g_static = p_static; g_level = p_level;
      g_cnt = 0; pend = 1'b0;
    end
    div_in = g_static ? g_level : (g_cnt < g_h);
    g_cnt  = g_static ? 0 : (g_cnt + 1) % g_n;
  end

  task automatic set_gen(input int n, input int h, input bit imm);
    p_n = n; p_h = h; p_static = 1'b0; p_level = 1'b0; p_imm = imm; pend = 1'b1;
  endtask

  task automatic set_static(input bit lvl);
    p_n = 1; p_h = 0; p_static = 1'b1; p_level = lvl; p_imm = 1'b1; pend = 1'b1;
  endtask

  // Reference model: timestamps of synchronized edges rather than counters.
  int cyc = 0, m_start = -1, m_fall = -1, m_match = 0, hh, ll;
  bit h1 = 0, h2 = 0, h3 = 0, m_idle = 1;
  int m_n = 0, m_hi = 0, m_lo = 0;
  bit m_valid = 0, m_odd = 0, m_locked = 0, m_ovf = 0, m_duty = 0;

  task automatic overflow_evt();
    m_ovf = 1; m_locked = 0; m_match = 0; m_start = -1; m_fall = -1;
  endtask

  task automatic publish_evt(input int h, input int l);
    int d;
    m_match  = (m_match != 0 && (h + l) == m_n) ? ((m_match < LOCK) ? m_match + 1 : LOCK) : 1;
    m_n = h + l; m_hi = h; m_lo = l; m_odd = m_n[0]; m_valid = 1;
    m_locked = (m_match >= LOCK);
    d = (h > l) ? h - l : l - h;
    m_duty = DUTY_ON && (d > 1);
  endtask

  always @(posedge clk) begin : model
    bit rs, fl;
    if (reset) begin
      h1 = 0; h2 = 0; h3 = 0; m_idle = 1; m_start = -1; m_fall = -1; m_match = 0;
      m_n = 0; m_hi = 0; m_lo = 0; m_valid = 0; m_odd = 0; m_locked = 0; m_ovf = 0; m_duty = 0;
    end else begin
      rs = h2 && !h3;
      fl = !h2 && h3;
      m_valid = 0;
      if (!enable) begin
        m_idle = 1; m_start = -1; m_fall = -1; m_locked = 0; m_ovf = 0; m_match = 0;
      end else if (m_idle) m_idle = 0;
      else if (m_start < 0) begin
        if (rs) begin m_start = cyc; m_fall = -1; end
      end else if (m_fall < 0) begin
        if (cyc - m_start >= MAXC) overflow_evt();
        else if (fl) m_fall = cyc;
      end else if (cyc - m_fall >= MAXC) overflow_evt();
      else if (rs) begin
        hh = m_fall - m_start;
        ll = cyc - m_fall;
        if (hh + ll > MAXC) overflow_evt();
        else begin publish_evt(hh, ll); m_start = cyc; m_fall = -1; end
      end
      h3 = h2; h2 = h1; h1 = div_in;
    end
    cyc++;
  end

  always @(posedge clk) begin
    #1;
    chk("n_meas", n_meas, m_n);
    chk("high_cnt", high_cnt, m_hi);
    chk("low_cnt", low_cnt, m_lo);
    chk("meas_valid", meas_valid, m_valid);
    chk("odd", odd, m_odd);
    chk("locked", locked, m_locked);
    chk("ovf", ovf, m_ovf);
    chk("duty_err", duty_err, m_duty);
  end

  task automatic wait_valid(input string tag, input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #2;
      if (meas_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL wait_%s: no meas_valid within %0d cycles, expected one", tag, maxc);
    end
  endtask

  initial begin
    #200000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int vcnt, r;
    bit found;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_n_meas", n_meas, 0);
    chk("rst_valid", meas_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk) reset = 1'b0;

    // Divide by 5, high 3 low 2: lock on the 4th publish.
    set_gen(5, 3, 1);
    @(negedge clk) enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_valid("n5", 40);
      if (k == 2) chk("lock_3rd", locked, 0);
    end
    chk("n5_locked", locked, 1);
    chk("n5_n", n_meas, 5);
    chk("n5_odd", odd, 1);
    chk("n5_hi", high_cnt, 3);
    chk("n5_lo", low_cnt, 2);

    // Change to N=7 while locked.
    set_gen(7, 4, 0);
    found = 0;
    for (int k = 0; k < 6; k++) begin
      wait_valid("n7a", 40);
      if (n_meas != 5) begin found = 1; break; end
    end
    chk("n7_first_n", n_meas, 7);
    chk("n7_first_unlocked", locked, 0);
    chk("n7_found", found, 1);
    for (int k = 0; k < 3; k++) wait_valid("n7b", 40);
    chk("n7_relock", locked, 1);
    chk("n7_n", n_meas, 7);

    // Even divide by 4, 50% duty.
    set_gen(4, 2, 0);
    for (int k = 0; k < 3; k++) wait_valid("n4", 40);
    chk("n4_n", n_meas, 4);
    chk("n4_hi", high_cnt, 2);
    chk("n4_lo", low_cnt, 2);
    chk("n4_odd", odd, 0);
    chk("n4_duty", duty_err, 0);

    // Period 4 with high 1, low 3.
    set_gen(4, 1, 0);
    for (int k = 0; k < 3; k++) wait_valid("n4d", 40);
    chk("n4d_hi", high_cnt, 1);
    chk("n4d_lo", low_cnt, 3);
    chk("n4d_duty", duty_err, DUTY_ON);

    // Static low: low counter saturates and ovf sets without a publish.
    set_static(1'b0);
    repeat (6) @(posedge clk);
    vcnt = 0;
    for (int i = 0; i < 40 && !ovf; i++) begin
      @(posedge clk); #2;
      if (meas_valid) vcnt++;
    end
    chk("static_ovf", ovf, 1);
    chk("static_locked", locked, 0);
    chk("static_no_valid", vcnt, 0);

    // Enable low clears flags and holds results.
    @(negedge clk) enable = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("dis_ovf", ovf, 0);
    chk("dis_locked", locked, 0);
    chk("dis_n_hold", n_meas, 4);

    // Reset mid low phase, then a clean first measurement.
    set_gen(5, 3, 0);
    @(negedge clk) enable = 1'b1;
    wait_valid("pre_rst", 40);
    wait_valid("pre_rst", 40);
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #2;
    chk("mid_rst_n", n_meas, 0);
    chk("mid_rst_hi", high_cnt, 0);
    chk("mid_rst_lo", low_cnt, 0);
    @(negedge clk) reset = 1'b0;
    wait_valid("post_rst", 40);
    chk("post_rst_n", n_meas, 5);
    chk("post_rst_hi", high_cnt, 3);
    chk("post_rst_lo", low_cnt, 2);

    // Randomized segments covered by the per-cycle model comparison.
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        @(negedge clk) reset = 1'b1;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        @(negedge clk) reset = 1'b0;
      end else if (r < 14) begin
        @(negedge clk) enable = 1'b0;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        @(negedge clk) enable = 1'b1;
      end else if (r < 20) begin
        set_static(1'($urandom_range(0, 1)));
      end else begin
        int n, h;
        n = $urandom_range(2, 20);
        h = $urandom_range(1, n - 1);
        set_gen(n, h, 1'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(8, 60)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/div_measure.md
DIV_MEASURE -- requirements
Module: div_measure

Interface
REQ-001 Parameter: LOCK_CNT, default 4, number of consecutive equal periods required to assert locked.
REQ-002 clk  input  1  measurement clock; the same clock that drives the divider under test.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  measurement enable; low forces IDLE.
REQ-005 div_in  input  1  divided clock to be measured; treated as asynchronous to clk.
REQ-006 n_meas  output  `SIZE  last measured period in clk cycles, equal to the division factor N.
REQ-007 high_cnt  output  `SIZE  clk samples with div_in high in the last period.
REQ-008 low_cnt  output  `SIZE  clk samples with div_in low in the last period.
REQ-009 meas_valid  output  1  one-cycle pulse when n_meas, high_cnt and low_cnt update.
REQ-010 odd  output  1  n_meas[0] of the last published result.
REQ-011 locked  output  1  LOCK_CNT consecutive identical periods seen.
REQ-012 ovf  output  1  sticky flag: a period counter saturated; cleared by reset or by enable going low.
REQ-013 duty_err  output  1  duty-cycle violation flag (see Configuration).

Function
REQ-014 div_in SHALL pass through a 2-flop synchronizer; rising and falling edges SHALL be detected on the synchronized signal, with 3 clk cycles of latency from div_in to edge pulse.
REQ-015 FSM states SHALL be IDLE, WAIT_RISE, MEAS_HIGH and MEAS_LOW.
REQ-016 IDLE -> WAIT_RISE when enable=1.
REQ-017 WAIT_RISE -> MEAS_HIGH on a rise pulse, loading the high counter with 1 and the low counter with 0.
REQ-018 MEAS_HIGH SHALL increment the high counter each cycle and go to MEAS_LOW on a fall pulse, loading the low counter with 1.
REQ-019 MEAS_LOW SHALL increment the low counter each cycle.
REQ-020 On a rise pulse in MEAS_LOW, the block SHALL publish n_meas=high+low, high_cnt and low_cnt, pulse meas_valid in the same cycle, and re-enter MEAS_HIGH with high=1 and low=0 (back-to-back periods, no lost edge).
REQ-021 The sum high+low SHALL be formed at width `SIZE+1; a carry out SHALL be treated as an overflow.
REQ-022 If either counter reaches all-ones, or the sum overflows, the block SHALL set ovf, discard the period, clear locked, and go to WAIT_RISE.
REQ-023 A static div_in, including the divide-by-1 case, therefore SHALL end in ovf.
REQ-024 A match counter SHALL increment when a published n_meas equals the previous one, and reset to 1 when it differs.
REQ-025 locked SHALL assert when the match counter reaches LOCK_CNT and stay asserted until a mismatch or an overflow occurs.
REQ-026 If enable falls in any state, the FSM SHALL return to IDLE in the next cycle, clear locked and ovf, and hold n_meas, high_cnt and low_cnt.
REQ-027 A fall pulse in WAIT_RISE SHALL be ignored.
REQ-028 Simultaneous rise and fall pulses are impossible after synchronization and need no handling.

Reset
REQ-029 While reset is high: FSM=IDLE, synchronizer flops=0, n_meas=high_cnt=low_cnt=0, meas_valid=0, odd=0, locked=0, ovf=0, duty_err=0, match counter=0.
REQ-030 Reset asserted mid-period SHALL discard the partial measurement; measurement restarts only on the first rise pulse after reset release.

Configuration
REQ-031 With DIV_MEASURE_DUTY_CHECK_EN defined: at each publish, duty_err SHALL be set to 1 when |high_cnt-low_cnt| > 1, else 0; it is registered with meas_valid.
REQ-032 Without DIV_MEASURE_DUTY_CHECK_EN defined: duty_err SHALL be tied to 0 and no comparator logic shall be present.

Structure
REQ-033 `SIZE SHALL come from the shared defines file; the FSM state encodings SHALL be added there as `DM_IDLE, `DM_WAIT_RISE, `DM_MEAS_HIGH and `DM_MEAS_LOW.
REQ-034 Sub-module edge_sync SHALL contain the 2-flop synchronizer plus a delay flop and SHALL output rise and fall pulses.

Verification
REQ-035 div_in from the odd divider with N=5 -> n_meas=5, odd=1, {high_cnt,low_cnt} in {2,3}/{3,2}, locked asserts on the 4th meas_valid.
REQ-036 Even divide N=4 (50% square wave) -> n_meas=4, high_cnt=2, low_cnt=2, odd=0, duty_err=0.
REQ-037 N changed 5->7 while locked -> locked drops on the first differing publish, then n_meas=7 and locked re-asserts after 4 equal periods.
REQ-038 div_in held at 0 after a rise, `SIZE=4 -> ovf=1 when the low counter reaches 15, locked=0, and no meas_valid.
REQ-039 Reset pulsed mid MEAS_LOW -> all outputs 0; the first post-reset meas_valid reports the full correct period.
REQ-040 With the macro defined, period 4 at high=1 and low=3 -> duty_err=1; with the macro undefined -> duty_err=0.
